// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: the controller
// state encoding and the default operand width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell shared by the serial datapath.
module Full_Adder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    // Sum and majority carry of the three input bits
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer. Operands are captured on an accepted start
// strobe and then fed LSB-first through a single Full_Adder cell, one bit
// per clock. The carry is held in a flip-flop between bits. The sum is
// assembled MSB-side in a shift register, so after WIDTH shifts it is
// aligned. Results hold until the next accepted start.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | waiting for start; busy=0, done=0
//   SHIFT | one bit added per clock, WIDTH clocks in total
//   DONE  | result valid, done=1 for exactly one clock
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter holds 0..WIDTH so it never wraps, even on the last shift.
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    // The only adder logic in the block: bit 0 of each operand plus carry
    Full_Adder u_full_adder (
        .s    (w_fa_s),
        .cout (w_fa_cout),
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry)
    );

    // New sum bit enters at the MSB; a 1-bit sum is simply replaced
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_fa_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_fa_s, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer FSM with datapath registers and registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_fa_cout;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum_sr;
    assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for timing,
// carry, collision and reset-abort scenarios, and a 2-bit instance swept
// exhaustively with start held high.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Accepts one add on the 8-bit instance (must be idle), scrambles the
    // operand inputs after acceptance, and watches 20 edges for done.
    task automatic run_add8(input logic [7:0] ia, input logic [7:0] ib,
                            input logic icin, output int lat, output int pulses);
        a = ia; b = ib; cin = icin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ia; b = ~ib; cin = ~icin;
        lat = -1; pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (lat < 0) lat = n;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; a = 0; b = 0; cin = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        #23;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy8 got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done8 got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum8 got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout8 got=%b exp=0", cout); end
        checks++; if ({busy2, done2, sum2, cout2} !== 5'b0) begin errors++; $display("FAIL reset_w2 got=%b exp=00000", {busy2, done2, sum2, cout2}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy8 got=%b exp=0", busy); end
    endtask

    task automatic test_timing;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tim_busy_accept got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tim_done_accept got=%b exp=0", done); end
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tim_done_early got=%b exp=0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tim_busy_shift got=%b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tim_done_at_w got=%b exp=1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tim_busy_done got=%b exp=1", busy); end
        checks++; if (sum !== 8'h96) begin errors++; $display("FAIL tim_sum got=%h exp=96", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL tim_cout got=%b exp=0", cout); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tim_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tim_busy_idle got=%b exp=0", busy); end
        @(posedge clk); #1;
        checks++; if (sum !== 8'h96) begin errors++; $display("FAIL tim_sum_hold got=%h exp=96", sum); end
    endtask

    task automatic test_carry;
        int lat, pulses;
        run_add8(8'hFF, 8'h01, 1'b0, lat, pulses);
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL ripple_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b exp=1", cout); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ripple_lat got=%0d exp=8", lat); end
        run_add8(8'hFF, 8'hFF, 1'b1, lat, pulses);
        checks++; if (sum !== 8'hFF) begin errors++; $display("FAIL max_sum got=%h exp=FF", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL max_cout got=%b exp=1", cout); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL max_pulses got=%0d exp=1", pulses); end
        run_add8(8'h81, 8'h42, 1'b1, lat, pulses);
        checks++; if ({cout, sum} !== 9'h0C4) begin errors++; $display("FAIL mix_result got=%h exp=0C4", {cout, sum}); end
    endtask

    task automatic test_busy_ignore;
        int lat, pulses;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h00; b = 8'h00;
        lat = -1; pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 2) begin start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1; end
            if (n == 3) begin
                start = 1'b0;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got=%b exp=1", busy); end
            end
            if (done) begin
                pulses++;
                if (lat < 0) lat = n;
            end
        end
        checks++; if (sum !== 8'h30) begin errors++; $display("FAIL ign_sum got=%h exp=30", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ign_cout got=%b exp=0", cout); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ign_lat got=%0d exp=8", lat); end
    endtask

    task automatic test_reset_abort;
        int lat, pulses, seen;
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
        end
        // four low bits of 5A+3C: A+C = 0x16, so partial sum 0x60 carry 1
        checks++; if (sum !== 8'h60) begin errors++; $display("FAIL abort_partial_sum got=%h exp=60", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL abort_partial_cout got=%b exp=1", cout); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL abort_cout got=%b exp=0", cout); end
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        run_add8(8'h03, 8'h04, 1'b0, lat, pulses);
        checks++; if ({cout, sum} !== 9'h007) begin errors++; $display("FAIL after_abort_result got=%h exp=007", {cout, sum}); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL after_abort_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] k;
        logic [2:0] exp_r;
        k = 5'd0;
        a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0; start2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_r = 3'(int'(a2) + int'(b2) + int'(cin2));
            @(posedge clk); #1;
            checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] busy got=%b exp=1", i, busy2); end
            k = 5'(i + 1);
            a2 = k[4:3]; b2 = k[2:1]; cin2 = k[0];
            @(posedge clk); #1;
            checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL b2b_early[%0d] done got=%b exp=0", i, done2); end
            @(posedge clk); #1;
            checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d] got=%b exp=1", i, done2); end
            checks++; if ({cout2, sum2} !== exp_r) begin errors++; $display("FAIL b2b_result[%0d] got=%0d exp=%0d", i, {cout2, sum2}, exp_r); end
            @(posedge clk); #1;
            checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL b2b_idle[%0d] busy,done got=%b exp=00", i, {busy2, done2}); end
        end
        start2 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_timing;
        test_carry;
        test_busy_ignore;
        test_reset_abort;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
